led_matrix_scan_pwm: RTL and testbench
======================================

# led_matrix_scan_pwm

Parametrised multiplexed LED-matrix scan engine with per-pixel PWM brightness and a double-buffered frame store. It sits between the pixel-write logic (ui_in/uio_in decode in the top-level wrapper) and the row/column output pins. It generalises the fixed single-bit row scanner to ROWS×COLS pixels of PWM_BITS grey levels. It adds anti-ghosting blanking and tear-free buffer swap at frame boundaries.

## Interface
- ROWS, 8, number of scanned rows (2..16)
- COLS, 8, number of column drivers (1..16)
- PWM_BITS, 4, brightness bits per pixel (1..6); MAX = 2^PWM_BITS − 1
- TICK_DIV, 16, clk cycles per PWM step (≥1)
- BLANK, 2, all-off cycles before each row (≥1)
- ROW_ACTIVE_HIGH, 1, row_out polarity
- COL_ACTIVE_HIGH, 1, col_out polarity

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  scan enable
- wr_valid  in  1  write strobe into back buffer
- wr_row  in  $clog2(ROWS)  write row address
- wr_col  in  $clog2(COLS)  write column address
- wr_level  in  PWM_BITS  pixel brightness
- swap_req  in  1  request back/front buffer swap (pulse)
- swap_pending  out  1  swap requested, not yet executed
- swap_done  out  1  one-cycle pulse when swap executes
- frame_start  out  1  one-cycle pulse at start of row 0 blanking
- row_out  out  ROWS  one-hot row drive (polarity per parameter)
- col_out  out  COLS  column drive (polarity per parameter)

## Operation
- Two banks of ROWS×COLS×PWM_BITS; front bank displayed, back bank written. Single bank-select bit.
- Write: wr_valid=1 stores wr_level at (wr_row, wr_col) of back bank at clk edge; always accepted, no ready. Out-of-range row/col: write dropped.
- Scan FSM states SCAN_BLANK, SCAN_ACTIVE; counters row_idx, step (0..MAX−1), div (0..TICK_DIV−1), blank_cnt.
- SCAN_BLANK: all rows/cols inactive for BLANK cycles → SCAN_ACTIVE, step=0, div=0.
- SCAN_ACTIVE: row row_idx active; col c active iff front[row_idx][c] > step. div counts to TICK_DIV−1 then step++. After last step's last div cycle → SCAN_BLANK, row_idx++ (wraps ROWS−1→0).
- Row period = BLANK + MAX·TICK_DIV cycles; frame = ROWS·row period. Level 0 never lit; level MAX lit for all active cycles.
- frame_start asserted during the first SCAN_BLANK cycle with row_idx=0.
- Swap: swap_req sets swap_pending (extra requests while pending absorbed). Executes on the cycle the FSM leaves SCAN_ACTIVE with row_idx=ROWS−1: bank-select flips, swap_pending clears, swap_done pulses. New frame starts on new front bank. Bank contents are not copied.
- swap_req in the same cycle as a swap execution: treated as a new request; swap_pending stays 1.
- en=0: FSM forced to SCAN_BLANK, row_idx/step/div/blank_cnt cleared, outputs inactive, frame_start held 0. A pending swap executes on the first en=0 cycle. Writes continue.
- en 0→1: scanning restarts at row 0 blanking; frame_start pulses.

## Timing
- row_out, col_out, frame_start, swap_done registered: reflect FSM state of the previous cycle (1-cycle latency).
- Write-to-display: a pixel written to the back bank appears no earlier than the first frame after the next swap.
- Reset (async assert, sync to clk on release by the wrapper): row_out/col_out all inactive, swap_pending=0, swap_done=0, frame_start=0, FSM SCAN_BLANK, row_idx=0, bank-select=0, both banks zero.
- Reset mid-frame: outputs go inactive immediately (async). Buffers are cleared.
- With en=1 held from reset release, frame_start is observed high on output cycle 1.

## Structure
- Package led_matrix_pkg: scan_state_t enum (SCAN_BLANK, SCAN_ACTIVE), function pwm_max(bits), polarity helper function.
- Sub-module led_matrix_fb: double-buffered store, write port into the back bank, combinational full-row read of the front bank, bank-select flip input.
- Top of block: scan FSM, counters, comparators, swap logic, output registers.

## Test plan
- ROWS=4, COLS=4, PWM_BITS=2, TICK_DIV=2, BLANK=1; all back pixels=3, swap, en=1 → each row active 6 of every 7 cycles, col_out=4'hF while active, frame period 28 cycles.
- Pixel (1,2)=1, others 0, swapped → col_out[2] high for 2 cycles per frame, only with row_out=4'b0010. Level 2 → 4 cycles.
- swap_req mid-frame at row 1 → swap_pending=1 until end of row 3 active. swap_done pulses once. Next frame_start shows new data, with no partial frame.
- Write to wr_row=5 (ROWS=4) → no bank change. Write during scan → front display unchanged until swap.
- en dropped mid-row with swap pending → outputs inactive next cycle, swap_done pulses. en re-raised → frame_start, scan from row 0.
- rst asserted mid-ACTIVE → row_out/col_out inactive without clock, swap_pending=0. Display shows zeros after release.

Source files
------------

// File: rtl/led_matrix_scan_pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_matrix_pkg
//  Purpose  : Shared types and helpers for the LED-matrix PWM scan engine.
//             scan_state_t - two-state row scanner (blanking / active)
//             pwm_max      - highest grey level for a given bit depth
//             drive_level  - maps a logical "on" to the physical pin level
//             idx_width    - address width for an N-entry index (min 1 bit)
//  Revision : 1.0 - initial release
// ============================================================================
package led_matrix_pkg;

    typedef enum logic [0:0] {
        SCAN_BLANK  = 1'b0,
        SCAN_ACTIVE = 1'b1
    } scan_state_t;

    function automatic int unsigned pwm_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    function automatic logic drive_level(input logic active, input logic active_high);
        return active_high ? active : ~active;
    endfunction

    // A single-entry dimension still needs a one-bit address port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_matrix_scan_pwm_fb.sv
`default_nettype none
// ============================================================================
//  Module   : led_matrix_fb
//  Purpose  : Double-buffered pixel store. Writes always land in the back
//             bank; the front bank is read one full row at a time for the
//             scanner. bank_flip exchanges the roles of the two banks
//             without copying contents.
//  Ports    : clk, rst        - clock, async active-high reset (clears all)
//             wr_valid/row/col/level - back-bank write port (out-of-range
//                              addresses are dropped)
//             bank_flip       - swap front/back at the next clock edge
//             rd_row          - front-bank row to present
//             rd_levels       - COLS levels of rd_row, column c at
//                              [c*PWM_BITS +: PWM_BITS]
//  Revision : 1.0 - initial release
// ============================================================================
module led_matrix_fb
    import led_matrix_pkg::*;
#(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned COLS     = 8,
    parameter int unsigned PWM_BITS = 4,
    localparam int unsigned c_row_w = idx_width(ROWS),
    localparam int unsigned c_col_w = idx_width(COLS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [c_row_w-1:0]       wr_row,
    input  logic [c_col_w-1:0]       wr_col,
    input  logic [PWM_BITS-1:0]      wr_level,
    input  logic                     bank_flip,
    input  logic [c_row_w-1:0]       rd_row,
    output logic [COLS*PWM_BITS-1:0] rd_levels
);

    logic [PWM_BITS-1:0] r_mem [2][ROWS][COLS];
    logic                r_bank_sel;   // index of the front (displayed) bank
    logic                w_wr_ok;

    assign w_wr_ok = wr_valid && (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank_sel <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < int'(ROWS); r++) begin
                    for (int c = 0; c < int'(COLS); c++) begin
                        r_mem[b][r][c] <= '0;
                    end
                end
            end
        end else begin
            if (bank_flip) begin
                r_bank_sel <= ~r_bank_sel;
            end
            // The write targets the bank that is back during this cycle,
            // even if a flip happens at the same edge.
            if (w_wr_ok) begin
                r_mem[~r_bank_sel][wr_row][wr_col] <= wr_level;
            end
        end
    end

    generate
        for (genvar c = 0; c < int'(COLS); c++) begin : g_rd_col
            assign rd_levels[c*PWM_BITS +: PWM_BITS] = r_mem[r_bank_sel][rd_row][c];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/led_matrix_scan_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : led_matrix_scan_pwm
//  Purpose  : Multiplexed LED-matrix scanner with per-pixel PWM brightness,
//             anti-ghosting blanking before every row and tear-free bank
//             swap at frame boundaries.
//  Ports    : clk, rst            - clock, async active-high reset
//             en                  - scan enable (0 = blank, counters cleared)
//             wr_valid/row/col/level - back-bank pixel write
//             swap_req            - request a front/back swap (pulse)
//             swap_pending        - a swap is waiting for the frame end
//             swap_done           - one-cycle pulse after a swap executes
//             frame_start         - one-cycle pulse for row 0 blanking
//             row_out             - one-hot row drive
//             col_out             - column drive
//             All drive/pulse outputs are registered (one cycle latency).
//  Revision : 1.0 - initial release
// ============================================================================
module led_matrix_scan_pwm
    import led_matrix_pkg::*;
#(
    parameter int unsigned ROWS            = 8,
    parameter int unsigned COLS            = 8,
    parameter int unsigned PWM_BITS        = 4,
    parameter int unsigned TICK_DIV        = 16,
    parameter int unsigned BLANK           = 2,
    parameter bit          ROW_ACTIVE_HIGH = 1'b1,
    parameter bit          COL_ACTIVE_HIGH = 1'b1,
    localparam int unsigned c_row_w = idx_width(ROWS),
    localparam int unsigned c_col_w = idx_width(COLS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                wr_valid,
    input  logic [c_row_w-1:0]  wr_row,
    input  logic [c_col_w-1:0]  wr_col,
    input  logic [PWM_BITS-1:0] wr_level,
    input  logic                swap_req,
    output logic                swap_pending,
    output logic                swap_done,
    output logic                frame_start,
    output logic [ROWS-1:0]     row_out,
    output logic [COLS-1:0]     col_out
);

    localparam int unsigned c_div_w   = idx_width(TICK_DIV);
    localparam int unsigned c_blank_w = idx_width(BLANK);

    localparam logic [PWM_BITS-1:0]  c_step_last  = PWM_BITS'(pwm_max(PWM_BITS) - 1);
    localparam logic [c_div_w-1:0]   c_div_last   = c_div_w'(TICK_DIV - 1);
    localparam logic [c_blank_w-1:0] c_blank_last = c_blank_w'(BLANK - 1);
    localparam logic [c_row_w-1:0]   c_row_last   = c_row_w'(ROWS - 1);
    localparam logic [ROWS-1:0]      c_row_idle   = {ROWS{~ROW_ACTIVE_HIGH}};
    localparam logic [COLS-1:0]      c_col_idle   = {COLS{~COL_ACTIVE_HIGH}};

    scan_state_t          r_state,     w_state_nxt;
    logic [c_row_w-1:0]   r_row_idx,   w_row_idx_nxt;
    logic [PWM_BITS-1:0]  r_step,      w_step_nxt;
    logic [c_div_w-1:0]   r_div,       w_div_nxt;
    logic [c_blank_w-1:0] r_blank_cnt, w_blank_nxt;
    logic                 w_row_done;

    logic                 r_swap_pending;
    logic                 w_swap_exec;
    logic                 w_active;
    logic                 w_frame_start;
    logic [COLS*PWM_BITS-1:0] w_front;
    logic [ROWS-1:0]      w_row_drv;
    logic [COLS-1:0]      w_col_drv;

    logic                 r_swap_done;
    logic                 r_frame_start;
    logic [ROWS-1:0]      r_row_out;
    logic [COLS-1:0]      r_col_out;

    led_matrix_fb #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .PWM_BITS (PWM_BITS)
    ) u_fb (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_level  (wr_level),
        .bank_flip (w_swap_exec),
        .rd_row    (r_row_idx),
        .rd_levels (w_front)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SCAN_BLANK;
            r_row_idx   <= '0;
            r_step      <= '0;
            r_div       <= '0;
            r_blank_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_row_idx   <= w_row_idx_nxt;
            r_step      <= w_step_nxt;
            r_div       <= w_div_nxt;
            r_blank_cnt <= w_blank_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_row_idx_nxt = r_row_idx;
        w_step_nxt    = r_step;
        w_div_nxt     = r_div;
        w_blank_nxt   = r_blank_cnt;
        w_row_done    = 1'b0;
        if (!en) begin
            // Parking in row 0 blanking makes re-enable start a fresh frame.
            w_state_nxt   = SCAN_BLANK;
            w_row_idx_nxt = '0;
            w_step_nxt    = '0;
            w_div_nxt     = '0;
            w_blank_nxt   = '0;
        end else begin
            case (r_state)
                SCAN_BLANK: begin
                    if (r_blank_cnt == c_blank_last) begin
                        w_state_nxt = SCAN_ACTIVE;
                        w_blank_nxt = '0;
                        w_step_nxt  = '0;
                        w_div_nxt   = '0;
                    end else begin
                        w_blank_nxt = r_blank_cnt + 1'b1;
                    end
                end
                SCAN_ACTIVE: begin
                    if (r_div == c_div_last) begin
                        w_div_nxt = '0;
                        if (r_step == c_step_last) begin
                            w_row_done    = 1'b1;
                            w_state_nxt   = SCAN_BLANK;
                            w_step_nxt    = '0;
                            w_row_idx_nxt = (r_row_idx == c_row_last) ? '0 : r_row_idx + 1'b1;
                        end else begin
                            w_step_nxt = r_step + 1'b1;
                        end
                    end else begin
                        w_div_nxt = r_div + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = SCAN_BLANK;
                end
            endcase
        end
    end

    // ---------------------------------------------------------- swap logic
    // A swap waits for the last active cycle of the last row so a frame is
    // never split across banks; while disabled nothing is shown, so it can
    // go at once.
    assign w_swap_exec = r_swap_pending &&
                         (!en || (w_row_done && (r_row_idx == c_row_last)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_swap_pending <= 1'b0;
        end else if (swap_req) begin
            r_swap_pending <= 1'b1;
        end else if (w_swap_exec) begin
            r_swap_pending <= 1'b0;
        end
    end

    // ------------------------------------------------------ output drives
    assign w_active      = en && (r_state == SCAN_ACTIVE);
    assign w_frame_start = en && (r_state == SCAN_BLANK) &&
                           (r_row_idx == '0) && (r_blank_cnt == '0);

    generate
        for (genvar r = 0; r < int'(ROWS); r++) begin : g_row_drv
            assign w_row_drv[r] = drive_level(w_active && (r_row_idx == c_row_w'(r)),
                                              ROW_ACTIVE_HIGH);
        end
        // A level L is lit for steps 0..L-1, i.e. L of the MAX steps.
        for (genvar c = 0; c < int'(COLS); c++) begin : g_col_drv
            assign w_col_drv[c] = drive_level(w_active &&
                                              (w_front[c*PWM_BITS +: PWM_BITS] > r_step),
                                              COL_ACTIVE_HIGH);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_out     <= c_row_idle;
            r_col_out     <= c_col_idle;
            r_swap_done   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_row_out     <= w_row_drv;
            r_col_out     <= w_col_drv;
            r_swap_done   <= w_swap_exec;
            r_frame_start <= w_frame_start;
        end
    end

    assign row_out      = r_row_out;
    assign col_out      = r_col_out;
    assign swap_done    = r_swap_done;
    assign frame_start  = r_frame_start;
    assign swap_pending = r_swap_pending;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scan_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_matrix_scan_pwm
//  Purpose  : Self-checking bench for led_matrix_scan_pwm. Main instance is
//             4x4, 2-bit PWM, TICK_DIV=2, BLANK=1 (row period 7, frame 28).
//             A 3x3, 1-bit instance exercises out-of-range write addresses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_matrix_scan_pwm;

    localparam int FRAME = 28;

    logic       clk = 1'b0;
    logic       rst, en, wr_valid, swap_req;
    logic [1:0] wr_row, wr_col, wr_level;
    logic       swap_pending, swap_done, frame_start;
    logic [3:0] row_out, col_out;

    logic       en2, wr_valid2, swap_req2;
    logic [1:0] wr_row2, wr_col2;
    logic [0:0] wr_level2;
    logic       swap_pending2, swap_done2, frame_start2;
    logic [2:0] row_out2, col_out2;

    led_matrix_scan_pwm #(
        .ROWS(4), .COLS(4), .PWM_BITS(2), .TICK_DIV(2), .BLANK(1),
        .ROW_ACTIVE_HIGH(1'b1), .COL_ACTIVE_HIGH(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_row(wr_row),
        .wr_col(wr_col), .wr_level(wr_level), .swap_req(swap_req),
        .swap_pending(swap_pending), .swap_done(swap_done),
        .frame_start(frame_start), .row_out(row_out), .col_out(col_out)
    );

    led_matrix_scan_pwm #(
        .ROWS(3), .COLS(3), .PWM_BITS(1), .TICK_DIV(1), .BLANK(1),
        .ROW_ACTIVE_HIGH(1'b1), .COL_ACTIVE_HIGH(1'b1)
    ) u_dut2 (
        .clk(clk), .rst(rst), .en(en2), .wr_valid(wr_valid2), .wr_row(wr_row2),
        .wr_col(wr_col2), .wr_level(wr_level2), .swap_req(swap_req2),
        .swap_pending(swap_pending2), .swap_done(swap_done2),
        .frame_start(frame_start2), .row_out(row_out2), .col_out(col_out2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int cnt [4][4];
    int row_act [4];
    int not_full, stray, bad_onehot, total;

    typedef struct {
        int r;
        int c;
        int lvl;
        int exp_on;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accum();
        if (!$onehot0(row_out)) bad_onehot++;
        if (row_out == 4'b0 && col_out != 4'b0) stray++;
        for (int r = 0; r < 4; r++) begin
            if (row_out[r]) begin
                row_act[r]++;
                if (col_out != 4'hF) not_full++;
                for (int c = 0; c < 4; c++) begin
                    if (col_out[c]) begin
                        cnt[r][c]++;
                        total++;
                    end
                end
            end
        end
    endtask

    // Called on the frame_start output cycle; covers exactly one frame.
    task automatic observe_frame();
        for (int r = 0; r < 4; r++) begin
            row_act[r] = 0;
            for (int c = 0; c < 4; c++) cnt[r][c] = 0;
        end
        not_full = 0; stray = 0; bad_onehot = 0; total = 0;
        accum();
        for (int k = 1; k < FRAME; k++) begin
            tick();
            accum();
        end
    endtask

    task automatic wait_fs(input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            seen = frame_start;
        end
        check(name, seen, 1'b1);
    endtask

    task automatic wait_row(input logic [3:0] pat, input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            seen = (row_out == pat);
        end
        check(name, seen, 1'b1);
    endtask

    task automatic write_px(input int r, input int c, input int lvl);
        wr_valid = 1'b1;
        wr_row   = 2'(r);
        wr_col   = 2'(c);
        wr_level = 2'(lvl);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic fill_back(input int lvl);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                write_px(r, c, lvl);
    endtask

    // Request a swap, wait for it, then align to the next frame_start.
    task automatic do_swap(input string name);
        logic seen;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        seen = swap_done;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            seen = swap_done;
        end
        check(name, seen, 1'b1);
        wait_fs({name, "_fs"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int p, pend_drop, lit_before, fs_cnt;
        logic seen;
        logic [3:0] row_at_done;
        logic pend_at_done;

        vecs[0] = '{1, 2, 1, 2};
        vecs[1] = '{1, 2, 2, 4};
        vecs[2] = '{1, 2, 3, 6};
        vecs[3] = '{0, 0, 3, 6};
        vecs[4] = '{3, 3, 2, 4};
        vecs[5] = '{2, 1, 0, 0};

        rst = 1'b1; en = 1'b0; wr_valid = 1'b0; swap_req = 1'b0;
        wr_row = '0; wr_col = '0; wr_level = '0;
        en2 = 1'b0; wr_valid2 = 1'b0; swap_req2 = 1'b0;
        wr_row2 = '0; wr_col2 = '0; wr_level2 = '0;
        repeat (3) tick();

        // ---- reset state
        check("rst_row_out", row_out, 4'h0);
        check("rst_col_out", col_out, 4'h0);
        check("rst_swap_pending", swap_pending, 1'b0);
        check("rst_swap_done", swap_done, 1'b0);
        check("rst_frame_start", frame_start, 1'b0);

        // ---- release with en held high: frame_start on output cycle 1
        en = 1'b1; en2 = 1'b1;
        rst = 1'b0;
        tick();
        check("fs_cycle1", frame_start, 1'b1);
        check("fs_cycle1_rows_off", row_out, 4'h0);
        p = 0; seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            p++;
            seen = frame_start;
        end
        check("frame_period", p, FRAME);

        // ---- zero banks show nothing
        observe_frame();
        check("zero_frame_lit", total, 0);
        check("zero_frame_row0_active", row_act[0], 6);

        // ---- all pixels at MAX
        fill_back(3);
        do_swap("swap_all3");
        observe_frame();
        for (int r = 0; r < 4; r++) check($sformatf("all3_row%0d_active", r), row_act[r], 6);
        check("all3_cols_not_full", not_full, 0);
        check("all3_stray_cols", stray, 0);
        check("all3_onehot", bad_onehot, 0);
        check("all3_total", total, 96);

        // ---- single-pixel brightness vectors
        foreach (vecs[i]) begin
            fill_back(0);
            write_px(vecs[i].r, vecs[i].c, vecs[i].lvl);
            do_swap($sformatf("swap_vec%0d", i));
            observe_frame();
            check($sformatf("vec%0d_pixel_on", i), cnt[vecs[i].r][vecs[i].c], vecs[i].exp_on);
            check($sformatf("vec%0d_others_on", i), total - cnt[vecs[i].r][vecs[i].c], 0);
        end

        // ---- back-bank write while scanning leaves the display alone
        write_px(0, 0, 3);
        wait_fs("nochange_fs");
        observe_frame();
        check("write_no_display_change", total, 0);

        // ---- swap requested during row 1 executes at the end of row 3
        // back bank holds (0,0)=3 and (3,3)=2 from the steps above
        wait_row(4'b0010, "wait_row1");
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("midswap_pending_set", swap_pending, 1'b1);
        pend_drop = 0; lit_before = 0; seen = 1'b0;
        row_at_done = '0; pend_at_done = 1'b1;
        for (int k = 0; k < 60 && !seen; k++) begin
            tick();
            if (col_out != 4'h0) lit_before++;
            if (swap_done) begin
                seen = 1'b1;
                row_at_done  = row_out;
                pend_at_done = swap_pending;
            end else if (!swap_pending) begin
                pend_drop++;
            end
        end
        check("midswap_done_seen", seen, 1'b1);
        check("midswap_done_row", row_at_done, 4'b1000);
        check("midswap_pending_cleared", pend_at_done, 1'b0);
        check("midswap_pending_held", pend_drop, 0);
        check("midswap_no_partial", lit_before, 0);
        tick();
        check("midswap_next_fs", frame_start, 1'b1);
        check("midswap_done_one_pulse", swap_done, 1'b0);
        observe_frame();
        check("midswap_px00", cnt[0][0], 6);
        check("midswap_px33", cnt[3][3], 4);
        check("midswap_total", total, 10);

        // ---- en dropped mid-row with a swap pending
        wait_row(4'b0100, "wait_row2");
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        en = 1'b0;
        check("endrop_pending_set", swap_pending, 1'b1);
        tick();
        check("endrop_rows_off", row_out, 4'h0);
        check("endrop_cols_off", col_out, 4'h0);
        check("endrop_swap_done", swap_done, 1'b1);
        check("endrop_pending_clear", swap_pending, 1'b0);
        fs_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (frame_start) fs_cnt++;
        end
        check("endrop_no_fs", fs_cnt, 0);
        check("endrop_done_low", swap_done, 1'b0);
        en = 1'b1;
        tick();
        check("reen_fs", frame_start, 1'b1);
        tick();
        check("reen_row0", row_out, 4'b0001);

        // ---- async reset in the middle of an active row
        fill_back(3);
        do_swap("swap_pre_rst");
        wait_row(4'b0010, "wait_row1_rst");
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("rst_mid_pending_before", swap_pending, 1'b1);
        check("rst_mid_cols_before", col_out, 4'hF);
        rst = 1'b1;
        #1;
        check("rst_mid_rows_off", row_out, 4'h0);
        check("rst_mid_cols_off", col_out, 4'h0);
        check("rst_mid_pending", swap_pending, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid_fs", frame_start, 1'b1);
        observe_frame();
        check("rst_mid_cleared_lit", total, 0);
        check("rst_mid_row1_active", row_act[1], 6);
        fill_back(0);
        do_swap("swap_post_rst");
        observe_frame();
        check("rst_mid_back_cleared", total, 0);

        // ---- 3x3 instance: out-of-range addresses dropped
        wr_valid2 = 1'b1; wr_level2 = 1'b1;
        wr_row2 = 2'd3; wr_col2 = 2'd0; tick();
        wr_row2 = 2'd0; wr_col2 = 2'd3; tick();
        wr_row2 = 2'd2; wr_col2 = 2'd2; tick();
        wr_valid2 = 1'b0;
        swap_req2 = 1'b1;
        tick();
        swap_req2 = 1'b0;
        seen = swap_done2;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            seen = swap_done2;
        end
        check("small_swap_done", seen, 1'b1);
        tick();
        check("small_fs", frame_start2, 1'b1);
        p = 0; total = 0;
        for (int k = 0; k < 6; k++) begin
            if (row_out2[2] && col_out2[2]) p++;
            for (int c = 0; c < 3; c++) if (row_out2 != 3'b0 && col_out2[c]) total++;
            tick();
        end
        check("small_px22_on", p, 1);
        check("small_total_on", total, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
